data_sync_tx: RTL and testbench

- Source-domain launcher for a multi-bit CDC crossing. Accepts a word over a valid/ready interface and drives a stable `unsync_bus` plus a level `bus_enable` toward the destination-domain data synchronizer.
- Runs a four-phase handshake against a level acknowledge returned from the destination domain. The acknowledge is resynchronized internally.
- `unsync_bus` never changes while `bus_enable` is high or while the acknowledge is still high.

---
 rtl/data_sync_pkg.sv | 19 +
 rtl/ack_sync.sv | 20 ++
 rtl/data_sync_tx.sv | 90 +++++++++
 tb/tb_data_sync_tx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/data_sync_pkg.sv
// Shared definitions for the CDC word launcher: FSM encoding and a
// constant clog2 used to size the REQ timeout counter.
package data_sync_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } tx_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/ack_sync.sv
// Multi-flop synchronizer bringing the destination-domain level ack into CLK.
module ack_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic ack_async,
    output logic ack_s
);

    logic [NUM_STAGES-1:0] chain;

    always_ff @(posedge CLK) begin
        if (!RST) chain <= '0;
        else      chain <= {chain[NUM_STAGES-2:0], ack_async};
    end

    assign ack_s = chain[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_tx.sv
// Source-side launcher: holds a word on unsync_bus and runs a four-phase
// level handshake (bus_enable / ack) with an optional REQ timeout.
module data_sync_tx
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH      = 8,
    parameter int NUM_STAGES     = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] src_data,
    input  logic                 src_valid,
    output logic                 src_ready,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 bus_enable,
    input  logic                 ack_async,
    output logic                 tx_done,
    output logic                 tx_timeout
);

    localparam int CW = (clog2(TIMEOUT_CYCLES + 1) > 0) ? clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    tx_state_t     state;
    logic [CW-1:0] cnt;
    logic          timed_out;
    logic          ack_s;

    ack_sync #(.NUM_STAGES(NUM_STAGES)) u_ack_sync (
        .CLK       (CLK),
        .RST       (RST),
        .ack_async (ack_async),
        .ack_s     (ack_s)
    );

    // A lingering ack from an aborted or timed-out transfer blocks new words.
    assign src_ready = (state == IDLE) && !ack_s;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            unsync_bus <= '0;
            bus_enable <= 1'b0;
            tx_done    <= 1'b0;
            tx_timeout <= 1'b0;
            cnt        <= '0;
            timed_out  <= 1'b0;
        end else begin
            tx_done    <= 1'b0;
            tx_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (src_valid && !ack_s) begin
                        unsync_bus <= src_data;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    bus_enable <= 1'b1;
                    cnt        <= '0;
                    timed_out  <= 1'b0;
                    state      <= REQ;
                end
                REQ: begin
                    // Ack takes priority over a timeout firing on the same edge.
                    if (ack_s) begin
                        bus_enable <= 1'b0;
                        state      <= RELEASE;
                    end else if (TIMEOUT_CYCLES > 0 && cnt == CNT_MAX) begin
                        bus_enable <= 1'b0;
                        tx_timeout <= 1'b1;
                        timed_out  <= 1'b1;
                        state      <= RELEASE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        tx_done <= !timed_out;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sync_tx.sv
// Randomized handshake bench: per-transfer event timing is derived from the
// ack schedule (sync latency, timeout bound) and compared cycle by cycle.
module tb_data_sync_tx;

    localparam int BW = 8;
    localparam int NS = 2;
    localparam int TO = 10;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [BW-1:0] src_data = '0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [BW-1:0] unsync_bus;
    logic          bus_enable;
    logic          ack_async = 1'b0;
    logic          tx_done;
    logic          tx_timeout;

    int n_chk = 0;
    int n_err = 0;

    data_sync_tx #(.BUS_WIDTH(BW), .NUM_STAGES(NS), .TIMEOUT_CYCLES(TO)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .unsync_bus (unsync_bus),
        .bus_enable (bus_enable),
        .ack_async  (ack_async),
        .tx_done    (tx_done),
        .tx_timeout (tx_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ack_async level during the cycle following edge t (t=0 is the edge raising bus_enable)
    function automatic bit ackv(input int t, input int ra, input int fa);
        return (ra >= 0) && (t >= ra) && (t < fa);
    endfunction

    // mode 0: valid low during transfer, 1: 8'hFF offered while busy, 2: next word held valid
    task automatic do_xfer(input logic [7:0] d, input int ra, input int fdly,
                           input int mode, input logic [7:0] nxt);
        int  f, x, fa, endt, w;
        bit  to;
        w = 0;
        while (!src_ready && w < 50) begin
            tick();
            w++;
        end
        chk("ready_before_accept", 32'(src_ready), 32'd1);
        src_data  = d;
        src_valid = 1'b1;
        tick();
        src_valid = 1'b0;
        chk("accept_bus", 32'(unsync_bus), 32'(d));
        chk("accept_en_low", 32'(bus_enable), 32'd0);
        chk("accept_ready_low", 32'(src_ready), 32'd0);
        tick();

        // Ack seen NS+1 edges after it rises; timeout bound wins only if strictly later.
        if (ra >= 0 && ra + NS + 1 <= TO) begin
            f  = ra + NS + 1;
            to = 1'b0;
        end else begin
            f  = TO;
            to = 1'b1;
        end
        fa = ((ra > f) ? ra : f) + fdly;
        x  = f + 1;
        while (ackv(x - 1 - NS, ra, fa) && x < 1000) x++;
        endt = x;
        if (ra >= 0 && fa + NS > endt) endt = fa + NS;

        for (int t = 0; t <= endt; t++) begin
            if (t > 0) tick();
            ack_async = ackv(t, ra, fa);
            if (t < x && mode == 1) begin
                src_valid = 1'b1;
                src_data  = 8'hFF;
            end else if (t < x && mode == 2) begin
                src_valid = 1'b1;
                src_data  = nxt;
            end else begin
                src_valid = 1'b0;
            end
            chk("bus_enable", 32'(bus_enable), 32'(t < f));
            chk("tx_done", 32'(tx_done), 32'(t == x && !to));
            chk("tx_timeout", 32'(tx_timeout), 32'(t == f && to));
            chk("src_ready", 32'(src_ready), 32'(t >= x && !ackv(t - NS, ra, fa)));
            chk("unsync_bus_hold", 32'(unsync_bus), 32'(d));
        end
        ack_async = 1'b0;
        src_valid = 1'b0;
    endtask

    initial begin
        int ra, fdly, mode;
        logic [7:0] d;
        RST = 1'b0;
        repeat (3) tick();
        RST = 1'b1;
        chk("rst_bus_enable", 32'(bus_enable), 32'd0);
        chk("rst_unsync_bus", 32'(unsync_bus), 32'd0);
        chk("rst_tx_done", 32'(tx_done), 32'd0);
        chk("rst_tx_timeout", 32'(tx_timeout), 32'd0);
        chk("rst_src_ready", 32'(src_ready), 32'd1);
        tick();

        do_xfer(8'hA5, 3, 3, 0, 8'h00);   // basic
        do_xfer(8'h11, 3, 3, 2, 8'h22);   // back-to-back, 22 held valid
        do_xfer(8'h22, 2, 2, 0, 8'h00);
        do_xfer(8'h5A, -1, 0, 0, 8'h00);  // timeout, no ack ever
        do_xfer(8'hC3, 12, 3, 0, 8'h00);  // late ack after timeout
        do_xfer(8'h77, 7, 2, 0, 8'h00);   // ack and timeout on the same edge
        do_xfer(8'h78, 8, 2, 0, 8'h00);   // ack one edge too late
        do_xfer(8'h79, 9, 2, 0, 8'h00);   // ack lands in IDLE after timeout
        do_xfer(8'h01, 0, 1, 0, 8'h00);   // fastest ack
        do_xfer(8'h5F, 4, 4, 1, 8'h00);   // FF offered while busy

        for (int i = 0; i < 25; i++) begin
            d    = 8'($urandom);
            ra   = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 14));
            fdly = int'($urandom_range(1, 5));
            mode = int'($urandom_range(0, 1));
            do_xfer(d, ra, fdly, mode, 8'h00);
        end

        // Reset during REQ aborts the transfer immediately
        src_data  = 8'h3C;
        src_valid = 1'b1;
        tick();
        src_valid = 1'b0;
        tick();
        chk("pre_rst_en", 32'(bus_enable), 32'd1);
        tick();
        RST = 1'b0;
        tick();
        RST = 1'b1;
        chk("midrst_bus_enable", 32'(bus_enable), 32'd0);
        chk("midrst_unsync_bus", 32'(unsync_bus), 32'd0);
        chk("midrst_src_ready", 32'(src_ready), 32'd1);
        chk("midrst_tx_done", 32'(tx_done), 32'd0);
        tick();
        chk("post_rst_idle_en", 32'(bus_enable), 32'd0);
        chk("post_rst_ready", 32'(src_ready), 32'd1);

        do_xfer(8'h96, 5, 2, 0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
